pipe_datapath: RTL

PIPE_DATAPATH -- requirements
Module: pipe_datapath

---
 rtl/datapath_pkg.sv | 37 +++
 rtl/pipe_datapath_hazard_unit.sv | 53 +++++
 rtl/pipe_datapath.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/datapath_pkg.sv
// Shared definitions for the five-stage pipelined datapath: ALU op codes,
// forwarding selects, control bundle and the default reset PC.
package datapath_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_W   = 2'b01,
    FWD_M   = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic       branch;
    logic       alusrc;
    logic       regdst;
    logic       jump;
    logic [2:0] alucontrol;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // Register 0 is hardwired, so it never creates a dependency.
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

endpackage

// File: rtl/pipe_datapath_hazard_unit.sv
// Stall, flush and forwarding decisions for the pipelined datapath.
module hazard_unit
  import datapath_pkg::*;
(
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] writeregE,
  input  logic       memtoregE,
  input  logic [4:0] writeregM,
  input  logic       regwriteM,
  input  logic [4:0] writeregW,
  input  logic       regwriteW,
  input  logic       pcsrcE,
  input  logic       jumpD,
  output logic       stallF,
  output logic       stallD,
  output logic       flushD,
  output logic       flushE,
  output fwd_sel_t   forwardaE,
  output fwd_sel_t   forwardbE
);

  logic lwstall;

  always_comb begin
    forwardaE = FWD_REG;
    if (regwriteM && reg_match(rsE, writeregM)) begin
      forwardaE = FWD_M;
    end else if (regwriteW && reg_match(rsE, writeregW)) begin
      forwardaE = FWD_W;
    end
  end

  always_comb begin
    forwardbE = FWD_REG;
    if (regwriteM && reg_match(rtE, writeregM)) begin
      forwardbE = FWD_M;
    end else if (regwriteW && reg_match(rtE, writeregW)) begin
      forwardbE = FWD_W;
    end
  end

  assign lwstall = memtoregE && (reg_match(writeregE, rsD) || reg_match(writeregE, rtD));

  // A taken branch or a jump redirects fetch, so a pending load-use stall is dropped.
  assign stallF = lwstall && !pcsrcE && !jumpD;
  assign stallD = stallF;
  assign flushD = pcsrcE || jumpD;
  assign flushE = pcsrcE || stallF;

endmodule

// File: rtl/pipe_datapath.sv
// Five-stage F/D/E/M/W pipelined datapath with forwarding, load-use stall,
// branch resolution in E and jump resolution in D.
module pipe_datapath
  import datapath_pkg::*;
#(
  parameter int          N        = 32,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  output logic [N-1:0] pcF,
  input  logic [31:0]  instrF,
  output logic [31:0]  instrD,
  input  logic         regwriteD,
  input  logic         memtoregD,
  input  logic         memwriteD,
  input  logic         branchD,
  input  logic         alusrcD,
  input  logic         regdstD,
  input  logic         jumpD,
  input  logic [2:0]   alucontrolD,
  output logic [N-1:0] aluoutM,
  output logic [N-1:0] writedataM,
  output logic         memwriteM,
  input  logic [N-1:0] readdataM
);

  localparam logic [N-1:0] PC_INIT = N'(RESET_PC);

  logic         stallF, stallD, flushD, flushE;
  fwd_sel_t     forwardaE, forwardbE;

  logic [N-1:0] pcplus4F, pcnextF;
  logic [N-1:0] pcplus4D, pcjumpD, signimmD, rd1D, rd2D;
  logic [4:0]   rsD, rtD, rdD;
  ctrl_t        ctrlD, ctrlE;

  logic [N-1:0] rd1E, rd2E, signimmE, pcplus4E;
  logic [N-1:0] srcaE, srcbE, writedataE, aluoutE, pcbranchE;
  logic [4:0]   rsE, rtE, rdE, writeregE;
  logic         zeroE, pcsrcE;

  logic         regwriteM, memtoregM;
  logic [4:0]   writeregM;

  logic         regwriteW, memtoregW;
  logic [N-1:0] aluoutW, readdataW, resultW;
  logic [4:0]   writeregW;

  logic [N-1:0] rf [32];
  logic         unused_jumpE;

  assign ctrlD = '{regwrite: regwriteD, memtoreg: memtoregD, memwrite: memwriteD,
                   branch: branchD, alusrc: alusrcD, regdst: regdstD, jump: jumpD,
                   alucontrol: alucontrolD};

  // Fetch
  assign pcplus4F = pcF + N'(4);

  always_comb begin
    pcnextF = pcplus4F;
    if (pcsrcE) begin
      pcnextF = pcbranchE;
    end else if (ctrlD.jump) begin
      pcnextF = pcjumpD;
    end else if (stallF) begin
      pcnextF = pcF;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcF <= PC_INIT;
    end else begin
      pcF <= pcnextF;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instrD   <= '0;
      pcplus4D <= '0;
    end else if (flushD) begin
      instrD   <= '0;
      pcplus4D <= '0;
    end else if (!stallD) begin
      instrD   <= instrF;
      pcplus4D <= pcplus4F;
    end
  end

  // Decode
  assign rsD      = instrD[25:21];
  assign rtD      = instrD[20:16];
  assign rdD      = instrD[15:11];
  assign signimmD = {{(N-16){instrD[15]}}, instrD[15:0]};
  assign pcjumpD  = {pcplus4D[N-1:28], instrD[25:0], 2'b00};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        rf[i] <= '0;
      end
    end else if (regwriteW && (writeregW != 5'd0)) begin
      rf[writeregW] <= resultW;
    end
  end

  // Write-through: a read of the register retiring this cycle sees the new value.
  always_comb begin
    rd1D = rf[rsD];
    if (rsD == 5'd0) begin
      rd1D = '0;
    end else if (regwriteW && (writeregW == rsD)) begin
      rd1D = resultW;
    end
  end

  always_comb begin
    rd2D = rf[rtD];
    if (rtD == 5'd0) begin
      rd2D = '0;
    end else if (regwriteW && (writeregW == rtD)) begin
      rd2D = resultW;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrlE    <= CTRL_BUBBLE;
      rd1E     <= '0;
      rd2E     <= '0;
      rsE      <= '0;
      rtE      <= '0;
      rdE      <= '0;
      signimmE <= '0;
      pcplus4E <= '0;
    end else begin
      ctrlE    <= flushE ? CTRL_BUBBLE : ctrlD;
      rd1E     <= rd1D;
      rd2E     <= rd2D;
      rsE      <= rsD;
      rtE      <= rtD;
      rdE      <= rdD;
      signimmE <= signimmD;
      pcplus4E <= pcplus4D;
    end
  end

  // Execute
  always_comb begin
    case (forwardaE)
      FWD_M:   srcaE = aluoutM;
      FWD_W:   srcaE = resultW;
      default: srcaE = rd1E;
    endcase
  end

  always_comb begin
    case (forwardbE)
      FWD_M:   writedataE = aluoutM;
      FWD_W:   writedataE = resultW;
      default: writedataE = rd2E;
    endcase
  end

  assign srcbE = ctrlE.alusrc ? signimmE : writedataE;

  always_comb begin
    aluoutE = '0;
    case (ctrlE.alucontrol)
      ALU_AND: aluoutE = srcaE & srcbE;
      ALU_OR:  aluoutE = srcaE | srcbE;
      ALU_ADD: aluoutE = srcaE + srcbE;
      ALU_SUB: aluoutE = srcaE - srcbE;
      ALU_SLT: aluoutE = {{(N-1){1'b0}}, ($signed(srcaE) < $signed(srcbE))};
      default: aluoutE = '0;
    endcase
  end

  assign zeroE        = (aluoutE == '0);
  assign writeregE    = ctrlE.regdst ? rdE : rtE;
  assign pcbranchE    = pcplus4E + (signimmE << 2);
  assign pcsrcE       = ctrlE.branch && zeroE;
  assign unused_jumpE = ctrlE.jump;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regwriteM  <= 1'b0;
      memtoregM  <= 1'b0;
      memwriteM  <= 1'b0;
      aluoutM    <= '0;
      writedataM <= '0;
      writeregM  <= '0;
    end else begin
      regwriteM  <= ctrlE.regwrite;
      memtoregM  <= ctrlE.memtoreg;
      memwriteM  <= ctrlE.memwrite;
      aluoutM    <= aluoutE;
      writedataM <= writedataE;
      writeregM  <= writeregE;
    end
  end

  // Memory / writeback
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regwriteW <= 1'b0;
      memtoregW <= 1'b0;
      aluoutW   <= '0;
      readdataW <= '0;
      writeregW <= '0;
    end else begin
      regwriteW <= regwriteM;
      memtoregW <= memtoregM;
      aluoutW   <= aluoutM;
      readdataW <= readdataM;
      writeregW <= writeregM;
    end
  end

  assign resultW = memtoregW ? readdataW : aluoutW;

  hazard_unit u_hazard (
    .rsD       (rsD),
    .rtD       (rtD),
    .rsE       (rsE),
    .rtE       (rtE),
    .writeregE (writeregE),
    .memtoregE (ctrlE.memtoreg),
    .writeregM (writeregM),
    .regwriteM (regwriteM),
    .writeregW (writeregW),
    .regwriteW (regwriteW),
    .pcsrcE    (pcsrcE),
    .jumpD     (ctrlD.jump),
    .stallF    (stallF),
    .stallD    (stallD),
    .flushD    (flushD),
    .flushE    (flushE),
    .forwardaE (forwardaE),
    .forwardbE (forwardbE)
  );

endmodule
